// File: rtl/wide_add_seq.sv
// Multi-beat wide adder/subtractor: one WORD_W-bit word per beat, LSW first,
// carry chained between beats through a word-level generate/propagate term.
module wide_add_seq #(
    parameter int WORD_W = 32,
    parameter int BEATS  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    input  logic              in_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic              out_last,
    output logic              out_cout,
    output logic              out_ovf
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    typedef enum logic [0:0] {
        ST_FIRST = 1'b0,
        ST_MID   = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               carry_r, carry_s;
    logic               sub_r, sub_s;

    logic               accept_s;
    logic               first_s;
    logic               last_s;
    logic               op_sub_s;
    logic               cin_s;
    logic [WORD_W-1:0]  b_x_s;
    logic [WORD_W:0]    gen_sum_s;
    logic               gen_s;
    logic               prop_s;
    logic               cout_s;
    logic [WORD_W-1:0]  sum_s;
    logic               ovf_s;

    // Ready depends only on the output register, never on in_valid.
    assign in_ready = !out_valid || out_ready;
    assign accept_s = in_valid && in_ready;

    // Per-beat datapath: word G/P with the chained carry resolved as G | P&cin.
    always_comb begin
        first_s   = (state_r == ST_FIRST);
        op_sub_s  = first_s ? in_sub : sub_r;
        cin_s     = first_s ? in_sub : carry_r;
        b_x_s     = in_b ^ {WORD_W{op_sub_s}};
        gen_sum_s = {1'b0, in_a} + {1'b0, b_x_s};
        gen_s     = gen_sum_s[WORD_W];
        prop_s    = &(in_a ^ b_x_s);
        cout_s    = gen_s | (prop_s & cin_s);
        sum_s     = in_a + b_x_s + {{(WORD_W-1){1'b0}}, cin_s};
        ovf_s     = (in_a[WORD_W-1] == b_x_s[WORD_W-1]) && (sum_s[WORD_W-1] != in_a[WORD_W-1]);
        last_s    = (BEATS == 1) ? 1'b1 : (!first_s && (cnt_r == CNT_LAST));
    end

    // Next-state logic for the beat sequencer and carry/sub bookkeeping.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        carry_s = carry_r;
        sub_s   = sub_r;
        if (accept_s) begin
            case (state_r)
                ST_FIRST: begin
                    sub_s = in_sub;
                    if (last_s) begin
                        carry_s = 1'b0;
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = ST_FIRST;
                    end else begin
                        carry_s = cout_s;
                        cnt_s   = CNT_W'(1);
                        state_s = ST_MID;
                    end
                end
                ST_MID: begin
                    if (last_s) begin
                        carry_s = 1'b0;
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = ST_FIRST;
                    end else begin
                        carry_s = cout_s;
                        cnt_s   = cnt_r + CNT_W'(1);
                        state_s = ST_MID;
                    end
                end
                default: begin
                    carry_s = 1'b0;
                    cnt_s   = {CNT_W{1'b0}};
                    sub_s   = 1'b0;
                    state_s = ST_FIRST;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FIRST;
            cnt_r   <= {CNT_W{1'b0}};
            carry_r <= 1'b0;
            sub_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            carry_r <= carry_s;
            sub_r   <= sub_s;
        end
    end

    // Output register: a new beat may replace a word leaving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= {WORD_W{1'b0}};
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (accept_s) begin
            out_valid <= 1'b1;
            out_sum   <= sum_s;
            out_last  <= last_s;
            out_cout  <= last_s & cout_s;
            out_ovf   <= last_s & ovf_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_wide_add_seq.sv
// Randomized self-checking bench for wide_add_seq against a full-width arithmetic model.
module tb_wide_add_seq;

    localparam int W = 32;
    localparam int N = 4;
    localparam int T = W * N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sub   = 1'b0;
    logic [W-1:0]  in_a     = '0;
    logic [W-1:0]  in_b     = '0;
    logic          out_ready = 1'b1;
    logic          in_ready, out_valid, out_last, out_cout, out_ovf;
    logic [W-1:0]  out_sum;

    logic          v1 = 1'b0, s1 = 1'b0, ordy1 = 1'b1;
    logic [W-1:0]  a1 = '0, b1 = '0;
    logic          rdy1, ovalid1, last1, cout1, ovf1;
    logic [W-1:0]  sum1;

    int rdy_mode = 0;
    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         last;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t         exp_q[$];
    logic [W+2:0] cap_q[$];
    logic [T-1:0] m_a, m_b;
    logic         m_sub;
    int           m_idx = 0;
    logic         prev_stall = 1'b0;
    logic [W+2:0] prev_word;

    wide_add_seq #(.WORD_W(W), .BEATS(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_last(out_last),
        .out_cout(out_cout), .out_ovf(out_ovf));

    wide_add_seq #(.WORD_W(W), .BEATS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
        .in_a(a1), .in_b(b1), .in_sub(s1), .out_valid(ovalid1),
        .out_ready(ordy1), .out_sum(sum1), .out_last(last1),
        .out_cout(cout1), .out_ovf(ovf1));

    task automatic chk(input string name, input logic [T:0] act, input logic [T:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Consumer-side ready pattern.
    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor + reference model: every output transfer is compared to the model.
    always @(negedge clk) begin
        exp_t         e;
        logic [T:0]   r;
        logic         carry, ovf;
        if (!rst_n) begin
            exp_q.delete();
            m_idx = 0;
            prev_stall = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_sum", out_sum, 0);
            chk("rst_out_flags", {out_last, out_cout, out_ovf}, 0);
        end else begin
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_word", {out_sum, out_last, out_cout, out_ovf}, prev_word);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum", out_sum, e.sum);
                    chk("last", out_last, e.last);
                    chk("cout", out_cout, e.cout);
                    chk("ovf", out_ovf, e.ovf);
                end
                cap_q.push_back({out_sum, out_last, out_cout, out_ovf});
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_sum, out_last, out_cout, out_ovf};
            if (in_valid && in_ready) begin
                if (m_idx == 0) begin
                    m_sub = in_sub;
                    m_a = '0;
                    m_b = '0;
                end
                m_a[m_idx*W +: W] = in_a;
                m_b[m_idx*W +: W] = in_b;
                if (m_sub) begin
                    r     = {1'b0, m_a} - {1'b0, m_b};
                    carry = ~r[T];
                    ovf   = (m_a[T-1] != m_b[T-1]) && (r[T-1] != m_a[T-1]);
                end else begin
                    r     = {1'b0, m_a} + {1'b0, m_b};
                    carry = r[T];
                    ovf   = (m_a[T-1] == m_b[T-1]) && (r[T-1] != m_a[T-1]);
                end
                e.sum  = r[m_idx*W +: W];
                e.last = (m_idx == N-1);
                e.cout = e.last & carry;
                e.ovf  = e.last & ovf;
                exp_q.push_back(e);
                m_idx = e.last ? 0 : m_idx + 1;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic acc;
        int   n;
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = s;
        acc = 1'b0; n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("beat_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_op(input logic [T-1:0] a, input logic [T-1:0] b, input logic s,
                           input logic tog, input int gap);
        logic si;
        for (int i = 0; i < N; i++) begin
            si = (i == 0 || !tog) ? s : 1'($urandom_range(0, 1));
            send_beat(a[i*W +: W], b[i*W +: W], si);
            if (gap > 0) idle($urandom_range(0, gap));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [T-1:0] rnd_wide();
        logic [T-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = $urandom;
        return v;
    endfunction

    task automatic check_cap(input string name, input logic [W+2:0] w0, input logic [W+2:0] w1,
                             input logic [W+2:0] w2, input logic [W+2:0] w3);
        chk({name, "_count"}, cap_q.size(), 4);
        if (cap_q.size() == 4) begin
            chk({name, "_w0"}, cap_q[0], w0);
            chk({name, "_w1"}, cap_q[1], w1);
            chk({name, "_w2"}, cap_q[2], w2);
            chk({name, "_w3"}, cap_q[3], w3);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t0;
        logic [T-1:0] ra, rb;
        logic [T-1:0] ones;
        ones = '1;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // BEATS=1 instance: add with carry out, then subtract with borrow.
        v1 = 1'b1; a1 = 32'hFFFF_FFFF; b1 = 32'h1; s1 = 1'b0;
        @(negedge clk);
        chk("b1_in_ready", rdy1, 1);
        @(posedge clk); #1;
        a1 = 32'h3; b1 = 32'h5; s1 = 1'b1;
        @(negedge clk);
        chk("b1_add_word", {ovalid1, sum1, last1, cout1, ovf1}, {1'b1, 32'h0, 1'b1, 1'b1, 1'b0});
        @(posedge clk); #1;
        v1 = 1'b0;
        @(negedge clk);
        chk("b1_sub_word", {ovalid1, sum1, last1, cout1, ovf1}, {1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0});
        @(posedge clk); #1;

        // Reset in the middle of an operation.
        send_beat(32'h5, 32'h6, 1'b0);
        send_beat(32'h7, 32'h8, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_word", {out_sum, out_last, out_cout, out_ovf}, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cap_q.delete();
        send_op(128'h1, 128'h1, 1'b0, 1'b0, 0);
        drain();
        check_cap("after_rst", {32'h2, 3'b000}, {32'h0, 3'b000}, {32'h0, 3'b000}, {32'h0, 3'b100});

        // Carry ripple across all words.
        cap_q.delete();
        send_op(ones, 128'h1, 1'b0, 1'b0, 0);
        drain();
        check_cap("ripple", {32'h0, 3'b000}, {32'h0, 3'b000}, {32'h0, 3'b000}, {32'h0, 3'b110});

        // Subtract with borrow; in_sub toggling on later beats is ignored.
        cap_q.delete();
        send_op(128'h0, 128'h1, 1'b1, 1'b1, 0);
        drain();
        check_cap("borrow", {32'hFFFF_FFFF, 3'b000}, {32'hFFFF_FFFF, 3'b000},
                  {32'hFFFF_FFFF, 3'b000}, {32'hFFFF_FFFF, 3'b100});

        // Signed overflow into the top bit.
        cap_q.delete();
        send_op({1'b0, ones[T-2:0]}, 128'h1, 1'b0, 1'b0, 0);
        drain();
        check_cap("overflow", {32'h0, 3'b000}, {32'h0, 3'b000}, {32'h0, 3'b000}, {32'h8000_0000, 3'b101});

        // Full throughput with a ready consumer.
        t0 = $time;
        send_op(rnd_wide(), rnd_wide(), 1'b0, 1'b0, 0);
        chk("throughput_cycles", int'(($time - t0) / 10), N);
        drain();

        // Backpressure: consumer stalls for 3 cycles with input pending.
        rdy_mode = 2;
        idle(1);
        ra = rnd_wide();
        rb = rnd_wide();
        fork
            send_op(ra, rb, 1'b1, 1'b0, 0);
            begin
                @(posedge clk);
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", in_ready, 0);
                end
                @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain();

        // Randomized operations with random gaps, sub toggles and consumer stalls.
        rdy_mode = 1;
        for (int k = 0; k < 40; k++) begin
            ra = rnd_wide();
            rb = rnd_wide();
            if ($urandom_range(0, 7) == 0) ra = ones;
            if ($urandom_range(0, 7) == 0) rb = '0;
            if ($urandom_range(0, 7) == 0) rb = ra;
            send_op(ra, rb, 1'($urandom_range(0, 1)), 1'b1, ($urandom_range(0, 1) == 0) ? 0 : 2);
        end
        rdy_mode = 0;
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
